// File: rtl/norm_unit.sv
// norm_unit: per-row |x| normalization ahead of the NxV datapath.
// A psum row is captured, reduced to a sum of magnitudes (optionally merged
// with the sibling core's partial sum), then each |x| is divided by the total
// with col parallel restoring dividers. The result is a signed bw-bit row.
module norm_unit #(
    parameter int bw      = 8,
    parameter int bw_psum = 19,
    parameter int col     = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [bw_psum*col-1:0] in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   ext_en,
    output logic [bw_psum+3:0]     sum_out,
    output logic                   sum_out_valid,
    input  logic [bw_psum+3:0]     sum_in,
    input  logic                   sum_in_valid,
    output logic [bw*col-1:0]      out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   busy
);

    localparam int SW = bw_psum + 4;      // local sum width
    localparam int AW = bw_psum + 1;      // |x| width, holds -2^(bw_psum-1) exactly
    localparam int TW = SW + 1;           // total width, local + sibling
    localparam int RW = SW + 2;           // remainder width, room for the 2*rem shift
    localparam int CW = $clog2(bw) + 1;

    typedef enum logic [2:0] {S_IDLE, S_SUM, S_XCHG, S_DIV, S_OUT} state_t;

    state_t                       state_q;
    logic [col-1:0][bw_psum-1:0]  data_q;
    logic                         ext_q;
    logic [col-1:0]               sign_q;
    logic [col-1:0][RW-1:0]       rem_q;
    logic [col-1:0][bw-1:0]       quot_q;
    logic [TW-1:0]                total_q;
    logic [CW-1:0]                cnt_q;
    logic [SW-1:0]                sum_out_q;
    logic                         sum_out_valid_q;
    logic [col-1:0][bw-1:0]       out_q;
    logic                         out_valid_q;

    logic [col-1:0][AW-1:0]       abs_d;
    logic [SW-1:0]                sum_d;
    logic [col-1:0]               ge_d;
    logic [col-1:0][RW-1:0]       rsub_d;
    logic [col-1:0][RW-1:0]       rem_d;
    logic [col-1:0][bw-1:0]       quot_d;
    logic [col-1:0][bw-1:0]       qsat_d;
    logic [col-1:0][bw-1:0]       out_d;

    // Magnitudes of the captured row and their sum.
    always_comb begin
        sum_d = '0;
        for (int i = 0; i < col; i++) begin
            abs_d[i] = data_q[i][bw_psum-1] ? (~{1'b1, data_q[i]}) + AW'(1)
                                            : {1'b0, data_q[i]};
            sum_d    = sum_d + SW'(abs_d[i]);
        end
    end

    // One restoring-division step per lane, plus saturation and sign restore.
    // The remainder starts at |x| <= total, so the first step yields the 2^(bw-1)
    // bit and only abs == total can set it; that case saturates to 2^(bw-1)-1.
    always_comb begin
        for (int i = 0; i < col; i++) begin
            ge_d[i]   = rem_q[i] >= {1'b0, total_q};
            rsub_d[i] = ge_d[i] ? rem_q[i] - {1'b0, total_q} : rem_q[i];
            rem_d[i]  = {rsub_d[i][RW-2:0], 1'b0};
            quot_d[i] = {quot_q[i][bw-2:0], ge_d[i]};
            qsat_d[i] = quot_d[i][bw-1] ? {1'b0, {(bw-1){1'b1}}} : quot_d[i];
            if (total_q == '0)
                out_d[i] = '0;
            else if (sign_q[i])
                out_d[i] = ~qsat_d[i] + bw'(1);
            else
                out_d[i] = qsat_d[i];
        end
    end

    // Row FSM: capture, sum, exchange, divide, hold output until accepted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= S_IDLE;
            data_q          <= '0;
            ext_q           <= 1'b0;
            sign_q          <= '0;
            rem_q           <= '0;
            quot_q          <= '0;
            total_q         <= '0;
            cnt_q           <= '0;
            sum_out_q       <= '0;
            sum_out_valid_q <= 1'b0;
            out_q           <= '0;
            out_valid_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        data_q  <= in_data;
                        ext_q   <= ext_en;
                        state_q <= S_SUM;
                    end
                end
                S_SUM: begin
                    sum_out_q       <= sum_d;
                    sum_out_valid_q <= 1'b1;
                    for (int i = 0; i < col; i++) begin
                        rem_q[i]  <= RW'(abs_d[i]);
                        sign_q[i] <= data_q[i][bw_psum-1];
                    end
                    quot_q  <= '0;
                    state_q <= S_XCHG;
                end
                S_XCHG: begin
                    // Sibling sum is only looked at here; stray pulses elsewhere are dropped.
                    if (!ext_q || sum_in_valid) begin
                        total_q         <= ext_q ? TW'(sum_out_q) + TW'(sum_in)
                                                 : TW'(sum_out_q);
                        sum_out_valid_q <= 1'b0;
                        cnt_q           <= '0;
                        state_q         <= S_DIV;
                    end
                end
                S_DIV: begin
                    rem_q  <= rem_d;
                    quot_q <= quot_d;
                    cnt_q  <= cnt_q + CW'(1);
                    if (cnt_q == CW'(bw - 1)) begin
                        out_q       <= out_d;
                        out_valid_q <= 1'b1;
                        state_q     <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // in_ready is gated by reset so nothing looks acceptable while held in reset.
    assign in_ready      = (state_q == S_IDLE) && reset;
    assign busy          = (state_q != S_IDLE);
    assign sum_out       = sum_out_q;
    assign sum_out_valid = sum_out_valid_q;
    assign out_data      = out_q;
    assign out_valid     = out_valid_q;

endmodule
